// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences instruction fetches and loads/stores over one shared memory port.
// Latency: store done at request+2; fetch/load done at request+2+READ_LAT.
// Backpressure: none; request pulses are latched as pending flags (same-type repeats merge).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   fetch_req             pulse: fetch instruction at PC
//   data_req, data_we     pulse: data access at Rdest (data_we=1 store, 0 load)
//   mem_rdata             synchronous memory read data (READ_LAT cycles after issue)
//   addr_sel, mem_we      address mux select (0=PC, 1=Rdest) and memory write enable
//   instr, ld_data        last fetched instruction / last loaded word
//   fetch_done, data_done one-cycle completion pulses
//   busy                  FSM active or a request pending
// Optional: define MEM_PERF_CNT_EN to add fetch_cnt and stall_cnt outputs.

module mem_access_seq #(
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              addr_sel,
   output logic              mem_we,
   output logic [DATA_W-1:0] instr,
   output logic [DATA_W-1:0] ld_data,
   output logic              fetch_done,
   output logic              data_done,
   output logic              busy
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [15:0]       fetch_cnt,
   output logic [15:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE
   } state_t;

   // Last WAIT count value before moving to CAPTURE; unused when READ_LAT == 1.
   localparam logic [1:0] WAIT_LAST = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

   state_t            state_q, state_d;
   logic              fetch_pend_q, fetch_pend_d;
   logic              data_pend_q, data_pend_d;
   logic              data_we_q, data_we_d;
   logic              svc_data_q, svc_data_d;
   logic              svc_we_q, svc_we_d;
   logic [1:0]        wait_cnt_q, wait_cnt_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] ld_data_q, ld_data_d;
   logic              fetch_done_q, fetch_done_d;
   logic              data_done_q, data_done_d;

   logic              fetch_clr;
   logic              data_clr;
   logic              data_avail;
   logic              fetch_avail;
   logic              we_eff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         fetch_pend_q <= 1'b0;
         data_pend_q  <= 1'b0;
         data_we_q    <= 1'b0;
         svc_data_q   <= 1'b0;
         svc_we_q     <= 1'b0;
         wait_cnt_q   <= 2'd0;
         instr_q      <= '0;
         ld_data_q    <= '0;
         fetch_done_q <= 1'b0;
         data_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pend_q <= fetch_pend_d;
         data_pend_q  <= data_pend_d;
         data_we_q    <= data_we_d;
         svc_data_q   <= svc_data_d;
         svc_we_q     <= svc_we_d;
         wait_cnt_q   <= wait_cnt_d;
         instr_q      <= instr_d;
         ld_data_q    <= ld_data_d;
         fetch_done_q <= fetch_done_d;
         data_done_q  <= data_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      svc_data_d   = svc_data_q;
      svc_we_d     = svc_we_q;
      wait_cnt_d   = wait_cnt_q;
      instr_d      = instr_q;
      ld_data_d    = ld_data_q;
      fetch_done_d = 1'b0;
      data_done_d  = 1'b0;
      fetch_clr    = 1'b0;
      data_clr     = 1'b0;
      addr_sel     = 1'b0;
      mem_we       = 1'b0;
      data_pend_d  = data_pend_q;
      data_we_d    = data_we_q;

      // A request arriving in IDLE is served without first waiting for its flag.
      data_avail  = data_pend_q | data_req;
      fetch_avail = fetch_pend_q | fetch_req;
      we_eff      = data_pend_q ? data_we_q : data_we;

      case (state_q)
         S_IDLE: begin
            if (data_avail) begin
               state_d    = S_ISSUE;
               svc_data_d = 1'b1;
               svc_we_d   = we_eff;
            end else if (fetch_avail) begin
               state_d    = S_ISSUE;
               svc_data_d = 1'b0;
               svc_we_d   = 1'b0;
            end
         end
         S_ISSUE: begin
            addr_sel = svc_data_q;
            mem_we   = svc_data_q & svc_we_q;
            if (svc_data_q && svc_we_q) begin
               state_d     = S_IDLE;
               data_clr    = 1'b1;
               data_done_d = 1'b1;
            end else if (READ_LAT > 1) begin
               state_d    = S_WAIT;
               wait_cnt_d = 2'd0;
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_WAIT: begin
            addr_sel = svc_data_q;
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         S_CAPTURE: begin
            state_d = S_IDLE;
            if (svc_data_q) begin
               ld_data_d   = mem_rdata;
               data_done_d = 1'b1;
               data_clr    = 1'b1;
            end else begin
               instr_d      = mem_rdata;
               fetch_done_d = 1'b1;
               fetch_clr    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Completion clears before a new pulse sets, so a pulse landing on the
      // completing edge is kept as a fresh request rather than lost.
      fetch_pend_d = (fetch_pend_q & ~fetch_clr) | fetch_req;
      if (data_req && !(data_pend_q && !data_clr)) begin
         data_pend_d = 1'b1;
         data_we_d   = data_we;
      end else begin
         data_pend_d = data_pend_q & ~data_clr;
      end
   end

   assign instr      = instr_q;
   assign ld_data    = ld_data_q;
   assign fetch_done = fetch_done_q;
   assign data_done  = data_done_q;
   assign busy       = (state_q != S_IDLE) | fetch_pend_q | data_pend_q;

`ifdef MEM_PERF_CNT_EN
   logic [15:0] fetch_cnt_q, fetch_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall_now;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      // Fetch waits either behind an active data access or because data wins
      // the IDLE arbitration this cycle.
      stall_now   = fetch_pend_q &
                    ((state_q != S_IDLE) ? svc_data_q : data_avail);
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (fetch_done_d && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
      if (stall_now && (stall_cnt_q != 16'hFFFF))    stall_cnt_d = stall_cnt_q + 16'd1;
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: directed test of mem_access_seq with READ_LAT=1 and READ_LAT=3 instances.
// Latency: cycle 0 is the request cycle; outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; both instances see identical request stimulus.

module tb_mem_access_seq;

   logic        clk;
   logic        reset;
   logic        fetch_req;
   logic        data_req;
   logic        data_we;
   logic [15:0] mem_rdata;

   logic        addr_sel_1, mem_we_1, fetch_done_1, data_done_1, busy_1;
   logic [15:0] instr_1, ld_data_1;
   logic        addr_sel_3, mem_we_3, fetch_done_3, data_done_3, busy_3;
   logic [15:0] instr_3, ld_data_3;
`ifdef MEM_PERF_CNT_EN
   logic [15:0] fetch_cnt_1, stall_cnt_1, fetch_cnt_3, stall_cnt_3;
`endif

   int checks = 0;
   int errors = 0;

   mem_access_seq #(.DATA_W(16), .READ_LAT(1)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .data_req   (data_req),
      .data_we    (data_we),
      .mem_rdata  (mem_rdata),
      .addr_sel   (addr_sel_1),
      .mem_we     (mem_we_1),
      .instr      (instr_1),
      .ld_data    (ld_data_1),
      .fetch_done (fetch_done_1),
      .data_done  (data_done_1),
      .busy       (busy_1)
`ifdef MEM_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt_1),
      .stall_cnt  (stall_cnt_1)
`endif
   );

   mem_access_seq #(.DATA_W(16), .READ_LAT(3)) u_dut3 (
      .clk        (clk),
      .reset      (reset),
      .fetch_req  (fetch_req),
      .data_req   (data_req),
      .data_we    (data_we),
      .mem_rdata  (mem_rdata),
      .addr_sel   (addr_sel_3),
      .mem_we     (mem_we_3),
      .instr      (instr_3),
      .ld_data    (ld_data_3),
      .fetch_done (fetch_done_3),
      .data_done  (data_done_3),
      .busy       (busy_3)
`ifdef MEM_PERF_CNT_EN
      ,
      .fetch_cnt  (fetch_cnt_3),
      .stall_cnt  (stall_cnt_3)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap();
      repeat (8) tick();
   endtask

   initial begin
      int n_done;
      int n_sel;
      int n_bad;

      reset     = 1'b1;
      fetch_req = 1'b0;
      data_req  = 1'b0;
      data_we   = 1'b0;
      mem_rdata = 16'h0000;
      #1;
      check_eq("rst_addr_sel", {31'd0, addr_sel_1}, 32'd0);
      check_eq("rst_mem_we",   {31'd0, mem_we_1},   32'd0);
      check_eq("rst_instr",    {16'd0, instr_1},    32'd0);
      check_eq("rst_ld_data",  {16'd0, ld_data_1},  32'd0);
      check_eq("rst_dones",    {30'd0, fetch_done_1, data_done_1}, 32'd0);
      check_eq("rst_busy",     {31'd0, busy_1},     32'd0);
      repeat (2) tick();
      reset = 1'b0;
      tick();

      // Fetch, READ_LAT=1
      mem_rdata = 16'hA5C3;
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      check_eq("fetch_c1_addr_sel", {31'd0, addr_sel_1}, 32'd0);
      check_eq("fetch_c1_busy",     {31'd0, busy_1},     32'd1);
      check_eq("fetch_c1_done",     {31'd0, fetch_done_1}, 32'd0);
      tick();
      check_eq("fetch_c2_done",     {31'd0, fetch_done_1}, 32'd0);
      tick();
      check_eq("fetch_c3_done",     {31'd0, fetch_done_1}, 32'd1);
      check_eq("fetch_c3_instr",    {16'd0, instr_1},      32'h0000A5C3);
      check_eq("fetch_c3_busy",     {31'd0, busy_1},       32'd0);
`ifdef MEM_PERF_CNT_EN
      check_eq("fetch_cnt_one",     {16'd0, fetch_cnt_1},  32'd1);
`endif
      tick();
      check_eq("fetch_c4_done",     {31'd0, fetch_done_1}, 32'd0);
      idle_gap();

      // Store
      data_req = 1'b1;
      data_we  = 1'b1;
      tick();
      data_req = 1'b0;
      data_we  = 1'b0;
      check_eq("store_c1_mem_we",   {31'd0, mem_we_1},   32'd1);
      check_eq("store_c1_addr_sel", {31'd0, addr_sel_1}, 32'd1);
      tick();
      check_eq("store_c2_mem_we",   {31'd0, mem_we_1},   32'd0);
      check_eq("store_c2_addr_sel", {31'd0, addr_sel_1}, 32'd0);
      check_eq("store_c2_done",     {31'd0, data_done_1}, 32'd1);
      check_eq("store_ld_data",     {16'd0, ld_data_1},  32'd0);
      tick();
      check_eq("store_c3_done",     {31'd0, data_done_1}, 32'd0);
      idle_gap();

      // Simultaneous load + fetch: load first
      mem_rdata = 16'h0042;
      fetch_req = 1'b1;
      data_req  = 1'b1;
      data_we   = 1'b0;
      tick();
      fetch_req = 1'b0;
      data_req  = 1'b0;
      check_eq("sim_c1_addr_sel", {31'd0, addr_sel_1}, 32'd1);
      check_eq("sim_c1_mem_we",   {31'd0, mem_we_1},   32'd0);
      repeat (2) tick();
      check_eq("sim_c3_data_done",  {31'd0, data_done_1},  32'd1);
      check_eq("sim_c3_fetch_done", {31'd0, fetch_done_1}, 32'd0);
      check_eq("sim_c3_ld_data",    {16'd0, ld_data_1},    32'h00000042);
      tick();
      check_eq("sim_c4_addr_sel", {31'd0, addr_sel_1}, 32'd0);
      check_eq("sim_c4_busy",     {31'd0, busy_1},     32'd1);
      repeat (2) tick();
      check_eq("sim_c6_fetch_done", {31'd0, fetch_done_1}, 32'd1);
      check_eq("sim_c6_data_done",  {31'd0, data_done_1},  32'd0);
      check_eq("sim_c6_instr",      {16'd0, instr_1},      32'h00000042);
      idle_gap();

      // Merge: fetch pulses in cycles 0 and 1
      mem_rdata = 16'h1234;
      fetch_req = 1'b1;
      tick();
      n_done = 0;
      for (int c = 1; c <= 10; c++) begin
         fetch_req = (c == 1);
         tick();
         if (fetch_done_1) n_done++;
      end
      check_eq("merge_done_count", n_done, 32'd1);
      check_eq("merge_busy_after", {31'd0, busy_1}, 32'd0);
      check_eq("merge_instr",      {16'd0, instr_1}, 32'h00001234);
      idle_gap();

      // Reset during store ISSUE
      data_req = 1'b1;
      data_we  = 1'b1;
      tick();
      data_req = 1'b0;
      data_we  = 1'b0;
      check_eq("rststore_c1_mem_we", {31'd0, mem_we_1}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("rststore_mem_we",   {31'd0, mem_we_1},   32'd0);
      check_eq("rststore_addr_sel", {31'd0, addr_sel_1}, 32'd0);
      check_eq("rststore_instr",    {16'd0, instr_1},    32'd0);
      check_eq("rststore_ld_data",  {16'd0, ld_data_1},  32'd0);
      check_eq("rststore_busy",     {31'd0, busy_1},     32'd0);
      tick();
      reset = 1'b0;
      n_bad = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (data_done_1 || mem_we_1 || fetch_done_1) n_bad++;
      end
      check_eq("rststore_no_done", n_bad, 32'd0);
      idle_gap();

      // READ_LAT=3 load
      mem_rdata = 16'hBEEF;
      data_req  = 1'b1;
      data_we   = 1'b0;
      tick();
      data_req = 1'b0;
      n_sel  = 0;
      n_done = 0;
      for (int c = 1; c <= 7; c++) begin
         if (addr_sel_3) n_sel++;
         if (c == 4) check_eq("rl3_c4_done", {31'd0, data_done_3}, 32'd0);
         if (c == 5) begin
            check_eq("rl3_c5_done",    {31'd0, data_done_3}, 32'd1);
            check_eq("rl3_c5_ld_data", {16'd0, ld_data_3},   32'h0000BEEF);
         end
         if (data_done_3) n_done++;
         tick();
      end
      check_eq("rl3_addr_sel_cycles", n_sel,  32'd3);
      check_eq("rl3_done_count",      n_done, 32'd1);
      idle_gap();

`ifdef MEM_PERF_CNT_EN
      // Fetch blocked behind a load
      mem_rdata = 16'h7777;
      fetch_req = 1'b1;
      data_req  = 1'b1;
      data_we   = 1'b0;
      tick();
      fetch_req = 1'b0;
      data_req  = 1'b0;
      idle_gap();
      check_eq("perf_stall_nonzero", {31'd0, (stall_cnt_1 != 16'd0)}, 32'd1);
      check_eq("perf_fetch_cnt",     {16'd0, fetch_cnt_1},             32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Sequencer on the processor side of the shared single-port memory address path.
- Arbitrates instruction-fetch and load/store requests from the control FSM.
- Drives the address-select line of the 10-bit PC/Rdest address mux and the memory write enable.
- Captures read data into instruction and load-data registers and signals completion with one-cycle done pulses.

Parameters:
- DATA_W, 16, memory data width in bits.
- READ_LAT, 1, synchronous memory read latency in cycles (legal range 1..4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_req  input  1  single-cycle pulse requesting an instruction fetch at PC
- data_req  input  1  single-cycle pulse requesting a data access at Rdest
- data_we  input  1  sampled with data_req: 1 = store, 0 = load
- mem_rdata  input  DATA_W  read data from memory
- addr_sel  output  1  to address mux: 0 = PC, 1 = Rdest
- mem_we  output  1  memory write enable
- instr  output  DATA_W  last fetched instruction
- ld_data  output  DATA_W  last loaded data word
- fetch_done  output  1  one-cycle pulse; instr updated this cycle
- data_done  output  1  one-cycle pulse; load or store complete
- busy  output  1  high when FSM is not IDLE or any request is pending

Behaviour:
- Reset (async, any state, mid-access included):
  - FSM goes to IDLE; pending flags clear; wait counter = 0.
  - addr_sel=0, mem_we=0, instr=0, ld_data=0, fetch_done=0, data_done=0.
  - No write is issued during or after reset.
- Request latching:
  - A request pulse sets its pending flag; data_we is stored with data_req.
  - A pulse arriving while the same type is already pending is merged (ignored).
  - A pulse arriving during an active access is held pending and serviced afterwards.
- States:
  - IDLE -> ISSUE when a request is pending or arriving this cycle.
  - Data has priority over fetch when both are present.
  - ISSUE (1 cycle): addr_sel = 1 for data, 0 for fetch; mem_we = 1 only for a store.
  - After a store, ISSUE -> IDLE and data_done pulses the next cycle.
  - After a read, ISSUE -> WAIT if READ_LAT > 1, else ISSUE -> CAPTURE.
  - WAIT holds addr_sel for READ_LAT-1 cycles.
  - CAPTURE: mem_rdata is valid. At the end edge, load it into instr or ld_data, pulse the matching done output the following cycle, clear that pending flag, and return to IDLE.
- Latency (READ_LAT=1), measured from the request cycle:
  - Fetch or load: done at cycle +3.
  - Store: done at cycle +2.
- Outputs:
  - addr_sel returns to 0 in IDLE.
  - instr and ld_data hold their values until the next capture.
  - Done pulses never last more than one cycle.
  - fetch_done and data_done never assert in the same cycle.

Optional Feature:
- Macro: MEM_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - fetch_cnt [15:0]: counts completed fetches; saturates at 16'hFFFF; reset to 0.
  - stall_cnt [15:0]: counts cycles in which fetch is pending but not in service because a data access has priority or is active; saturates; reset to 0.
- When undefined, neither port nor counter exists and the rest of the behaviour is identical.

Test Plan:
- Fetch with READ_LAT=1, mem_rdata=16'hA5C3: fetch_req at cycle 0 -> addr_sel=0 during ISSUE; instr=16'hA5C3 and fetch_done=1 at cycle 3 only; busy drops at cycle 3.
- Store: data_req=1, data_we=1 at cycle 0 -> mem_we=1 and addr_sel=1 for exactly cycle 1; data_done=1 at cycle 2; ld_data unchanged.
- Simultaneous: fetch_req and data_req (load, mem_rdata=16'h0042) both in cycle 0 -> load serviced first with data_done at cycle 3, ld_data=16'h0042; fetch follows with fetch_done at cycle 6.
- Merge: fetch_req pulsed at cycles 0 and 1 -> exactly one fetch_done; busy low afterwards.
- Reset mid-store: assert reset during the ISSUE cycle of a store -> mem_we drops immediately; all outputs 0; no done pulse after reset deasserts.
- READ_LAT=3 load -> addr_sel=1 for 3 cycles; data_done at cycle +5.
  - With MEM_PERF_CNT_EN defined, a fetch blocked behind a load gives stall_cnt > 0.
  - fetch_cnt increments by one per fetch_done.
